// File: rtl/ptos_pkg.sv
// Shared types and constants for the parallel-to-serial stimulus sequencer.
package ptos_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StGap,
        StDone
    } ptos_state_e;

    localparam int unsigned PTOS_MODE_CNT  = 0;
    localparam int unsigned PTOS_MODE_LFSR = 1;

    function automatic int unsigned ptos_max3(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ptos_stim_sequencer_pattern.sv
// Data word source: incrementing counter or Galois LFSR, loaded by init and advanced by step.
module ptos_pattern_gen import ptos_pkg::*; #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      MODE  = PTOS_MODE_CNT,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init,
    input  logic             step,
    output logic [WIDTH-1:0] data
);

    // An all-zero LFSR state would lock up, so a zero seed starts from 1 instead.
    localparam logic [WIDTH-1:0] INIT_WORD =
        (MODE == PTOS_MODE_LFSR && SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        if (MODE == PTOS_MODE_LFSR) begin
            w_next = (r_data >> 1) ^ (r_data[0] ? TAPS : '0);
        end else begin
            w_next = r_data + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (init) begin
            r_data <= INIT_WORD;
        end else if (step) begin
            r_data <= w_next;
        end
    end

    assign data = r_data;

endmodule

// File: rtl/ptos_stim_sequencer.sv
// Handshaked burst sequencer driving load_send and the parallel word into a serializer.
module ptos_stim_sequencer import ptos_pkg::*; #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      NUM_WORDS   = 4,
    parameter int unsigned      LOAD_CYCLES = 1,
    parameter int unsigned      GAP_CYCLES  = 2,
    parameter int unsigned      MODE        = PTOS_MODE_CNT,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8),
    localparam int unsigned     IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             ready,
    output logic             load_send,
    output logic [WIDTH-1:0] data,
    output logic [IDX_W-1:0] word_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(ptos_max3(WIDTH, LOAD_CYCLES, GAP_CYCLES) + 1);

    localparam logic [CW-1:0]    LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0]    SEND_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    ptos_state_e      r_state;
    logic [CW-1:0]    r_cnt;
    logic [IDX_W-1:0] r_word_idx;
    logic             r_load_send;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_rst_sync;

    logic w_run;
    logic w_init;
    logic w_step;
    logic w_load_exit;
    logic w_send_end;
    logic w_last_word;

    // Reset asserts asynchronously but its release is retimed before a burst may begin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run       = r_rst_sync[1];
    assign w_last_word = (r_word_idx == IDX_LAST);
    assign w_send_end  = (r_state == StSend) && (r_cnt == SEND_LAST);
    assign w_init      = (r_state == StIdle) && start && w_run;
    assign w_load_exit = (r_state == StLoad) && (r_cnt >= LOAD_LAST) && ready;
    assign w_step      = (w_send_end && !w_last_word && (GAP_CYCLES == 0)) ||
                         ((r_state == StGap) && (r_cnt == GAP_LAST));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_word_idx  <= '0;
            r_load_send <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_init) begin
                        r_state    <= StLoad;
                        r_cnt      <= '0;
                        r_word_idx <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (w_load_exit) begin
                        r_state     <= StSend;
                        r_cnt       <= '0;
                        r_load_send <= 1'b1;
                    end else if (r_cnt < LOAD_LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StSend: begin
                    if (w_send_end) begin
                        r_load_send <= 1'b0;
                        r_cnt       <= '0;
                        if (w_last_word) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if (w_step) begin
                            r_state    <= StLoad;
                            r_word_idx <= r_word_idx + IDX_W'(1);
                        end else begin
                            r_state <= StGap;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StGap: begin
                    if (w_step) begin
                        r_state    <= StLoad;
                        r_cnt      <= '0;
                        r_word_idx <= r_word_idx + IDX_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    ptos_pattern_gen #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_pattern (
        .clock (clock),
        .reset (reset),
        .init  (w_init),
        .step  (w_step),
        .data  (data)
    );

    assign load_send = r_load_send;
    assign word_idx  = r_word_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ptos_stim_sequencer.sv
// Directed bench: per-cycle expected traces queued at start, popped and compared each cycle.
module tb_ptos_stim_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic       a_start, a_ready, a_ls, a_busy, a_done;
    logic [7:0] a_data;
    logic       a_idx;
    logic       b_start, b_ready, b_ls, b_busy, b_done;
    logic [7:0] b_data;
    logic [1:0] b_idx;
    logic       c_start, c_ready, c_ls, c_busy, c_done;
    logic [7:0] c_data;
    logic       c_idx;

    ptos_stim_sequencer #(
        .WIDTH(8), .NUM_WORDS(2), .LOAD_CYCLES(1), .GAP_CYCLES(0),
        .MODE(0), .SEED(8'hA5), .TAPS(8'hB8)
    ) u_a (
        .clock(clock), .reset(reset), .start(a_start), .ready(a_ready),
        .load_send(a_ls), .data(a_data), .word_idx(a_idx), .busy(a_busy), .done(a_done)
    );

    ptos_stim_sequencer #(
        .WIDTH(8), .NUM_WORDS(3), .LOAD_CYCLES(1), .GAP_CYCLES(0),
        .MODE(1), .SEED(8'h00), .TAPS(8'hB8)
    ) u_b (
        .clock(clock), .reset(reset), .start(b_start), .ready(b_ready),
        .load_send(b_ls), .data(b_data), .word_idx(b_idx), .busy(b_busy), .done(b_done)
    );

    ptos_stim_sequencer #(
        .WIDTH(8), .NUM_WORDS(2), .LOAD_CYCLES(1), .GAP_CYCLES(2),
        .MODE(0), .SEED(8'hFF), .TAPS(8'hB8)
    ) u_c (
        .clock(clock), .reset(reset), .start(c_start), .ready(c_ready),
        .load_send(c_ls), .data(c_data), .word_idx(c_idx), .busy(c_busy), .done(c_done)
    );

    typedef struct {
        logic       ls;
        logic [7:0] data;
        int         idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   sel;
    int   n_checks;
    int   n_err;

    logic        obs_ls, obs_busy, obs_done;
    logic [7:0]  obs_data;
    logic [31:0] obs_idx;

    always_comb begin
        obs_ls   = a_ls;
        obs_data = a_data;
        obs_idx  = 32'(a_idx);
        obs_busy = a_busy;
        obs_done = a_done;
        if (sel == 1) begin
            obs_ls   = b_ls;
            obs_data = b_data;
            obs_idx  = 32'(b_idx);
            obs_busy = b_busy;
            obs_done = b_done;
        end else if (sel == 2) begin
            obs_ls   = c_ls;
            obs_data = c_data;
            obs_idx  = 32'(c_idx);
            obs_busy = c_busy;
            obs_done = c_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic [7:0] step_word(input int mode, input logic [7:0] d);
        if (mode == 1) return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
        return d + 8'd1;
    endfunction

    // Expected outputs for every cycle after the start edge, WIDTH=8 and LOAD_CYCLES=1.
    task automatic push_burst(input int mode, input logic [7:0] first, input int nwords,
                              input int gap, input int hold, input int tail);
        logic [7:0] d;
        d = first;
        for (int w = 0; w < nwords; w++) begin
            if (w > 0) d = step_word(mode, d);
            for (int i = 0; i < 1 + ((w == 0) ? hold : 0); i++) q.push_back('{1'b0, d, w, 1'b1, 1'b0});
            for (int i = 0; i < 8; i++) q.push_back('{1'b1, d, w, 1'b1, 1'b0});
            if (w < nwords - 1) begin
                for (int i = 0; i < gap; i++) q.push_back('{1'b0, d, w, 1'b1, 1'b0});
            end
        end
        q.push_back('{1'b0, d, nwords - 1, 1'b1, 1'b1});
        for (int i = 0; i <= tail; i++) q.push_back('{1'b0, d, nwords - 1, 1'b0, 1'b0});
    endtask

    task automatic drive(input int s, input logic st, input logic rd);
        case (s)
            0: begin a_start = st; a_ready = rd; end
            1: begin b_start = st; b_ready = rd; end
            default: begin c_start = st; c_ready = rd; end
        endcase
    endtask

    // Called mid-cycle; this cycle is cycle 0 and start is sampled at its closing edge.
    task automatic play(input int s, input int ready_low_to, input int pulse0, input int pulse1,
                        input string name);
        exp_t e;
        int   c;
        sel = s;
        drive(s, 1'b1, 1'b1);
        c = 0;
        while (q.size() > 0) begin
            @(negedge clock);
            c++;
            e = q.pop_front();
            chk($sformatf("%s c%0d load_send", name, c), 32'(obs_ls), 32'(e.ls));
            chk($sformatf("%s c%0d data", name, c), 32'(obs_data), 32'(e.data));
            chk($sformatf("%s c%0d word_idx", name, c), obs_idx, 32'(e.idx));
            chk($sformatf("%s c%0d busy", name, c), 32'(obs_busy), 32'(e.busy));
            chk($sformatf("%s c%0d done", name, c), 32'(obs_done), 32'(e.done));
            drive(s, (c == pulse0) || (c == pulse1), !(c >= 1 && c <= ready_low_to));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        sel      = 0;
        reset    = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset%0d load_send", s), 32'(obs_ls), 32'd0);
            chk($sformatf("reset%0d data", s), 32'(obs_data), 32'd0);
            chk($sformatf("reset%0d word_idx", s), obs_idx, 32'd0);
            chk($sformatf("reset%0d busy", s), 32'(obs_busy), 32'd0);
            chk($sformatf("reset%0d done", s), 32'(obs_done), 32'd0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clock);

        push_burst(0, 8'hA5, 2, 0, 0, 2);
        play(0, 0, -1, -1, "a_basic");

        push_burst(0, 8'hA5, 2, 0, 4, 2);
        play(0, 4, -1, -1, "a_ready");

        push_burst(1, 8'h01, 3, 0, 0, 2);
        play(1, 0, -1, -1, "b_lfsr");

        push_burst(0, 8'hFF, 2, 2, 0, 2);
        play(2, 0, -1, -1, "c_gap");

        // Starts during SEND (cycle 5) and DONE (cycle 19) must not spawn another burst.
        push_burst(0, 8'hA5, 2, 0, 0, 4);
        play(0, 0, 5, 19, "a_ignore");

        sel = 0;
        drive(0, 1'b1, 1'b1);
        @(negedge clock);
        drive(0, 1'b0, 1'b1);
        repeat (11) @(negedge clock);
        chk("mid load_send", 32'(a_ls), 32'd1);
        chk("mid word_idx", 32'(a_idx), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst load_send", 32'(a_ls), 32'd0);
        chk("rst busy", 32'(a_busy), 32'd0);
        chk("rst data", 32'(a_data), 32'd0);
        chk("rst word_idx", 32'(a_idx), 32'd0);
        chk("rst done", 32'(a_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("rst hold%0d done", i), 32'(a_done), 32'd0);
            chk($sformatf("rst hold%0d busy", i), 32'(a_busy), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("post rst%0d done", i), 32'(a_done), 32'd0);
        end

        push_burst(0, 8'hA5, 2, 0, 0, 2);
        play(0, 0, -1, -1, "a_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
